// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH entries of {instruction, PC}, valid/ready on both sides.
// Flush empties the queue for branch/jump redirect; head outputs fall back to NOP_INS/0 when empty.
module if_id_queue #(
  parameter int               INS_W   = 32,
  parameter int               PC_W    = 32,
  parameter int               DEPTH   = 2,
  parameter logic [INS_W-1:0] NOP_INS = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INS_W-1:0]             InsIn,
  input  logic [PC_W-1:0]              PC_In,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [INS_W-1:0]             InsOut,
  output logic [PC_W-1:0]              PC_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         IF_flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [INS_W-1:0] insMem [DEPTH];
  logic [PC_W-1:0]  pcMem  [DEPTH];
  ptr_t             rdPtr;
  ptr_t             wrPtr;
  logic             full;
  logic             push;
  logic             pop;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic ptr_t nextPtr(input ptr_t p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign in_ready  = ~full & ~IF_flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign InsOut = out_valid ? insMem[rdPtr] : NOP_INS;
  assign PC_out = out_valid ? pcMem[rdPtr]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (IF_flush) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      insMem[wrPtr] <= InsIn;
      pcMem[wrPtr]  <= PC_In;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: four depths (2..5) share one stimulus stream; each has its own
// scoreboard queue, filled at issue time and drained by a per-instance negedge monitor.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InsIn;
  logic [31:0] PC_In;
  logic        in_valid;
  logic        out_ready;
  logic        IF_flush;

  logic        irA  [4];
  logic        ovA  [4];
  logic [31:0] insA [4];
  logic [31:0] pcA  [4];
  logic [2:0]  cntA [4];

  logic [63:0] sbq [4][$];
  logic        acc [4];

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam int D = g + 2;
    logic [$clog2(D+1)-1:0] cnt;
    logic [63:0]            head;

    if_id_queue #(.INS_W(32), .PC_W(32), .DEPTH(D), .NOP_INS(32'h0)) dut (
      .clk(clk), .reset(reset), .InsIn(InsIn), .PC_In(PC_In),
      .in_valid(in_valid), .in_ready(irA[g]), .InsOut(insA[g]), .PC_out(pcA[g]),
      .out_valid(ovA[g]), .out_ready(out_ready), .IF_flush(IF_flush), .count(cnt)
    );
    assign cntA[g] = 3'(cnt);

    always @(negedge clk) begin
      if (reset) begin
        sbq[g].delete();
        chk($sformatf("D%0d rst count", D), 64'(cntA[g]), 64'd0);
        chk($sformatf("D%0d rst out_valid", D), 64'(ovA[g]), 64'd0);
        chk($sformatf("D%0d rst InsOut", D), 64'(insA[g]), 64'd0);
      end else begin
        chk($sformatf("D%0d count", D), 64'(cntA[g]), 64'(sbq[g].size()));
        chk($sformatf("D%0d countMax", D), 64'(cntA[g] <= 3'(D)), 64'd1);
        chk($sformatf("D%0d out_valid", D), 64'(ovA[g]), 64'(sbq[g].size() != 0));
        chk($sformatf("D%0d in_ready", D), 64'(irA[g]),
            64'((sbq[g].size() != D) && !IF_flush));
        if (sbq[g].size() != 0) begin
          head = sbq[g][0];
          chk($sformatf("D%0d head", D), {insA[g], pcA[g]}, head);
          if (out_ready) void'(sbq[g].pop_front());
        end else begin
          chk($sformatf("D%0d empty head", D), {insA[g], pcA[g]}, 64'd0);
        end
      end
    end
  end

  // Drive one cycle; expected entries are queued after the monitor has compared this cycle.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid  = iv;
    InsIn     = ins;
    PC_In     = pc;
    out_ready = ordy;
    IF_flush  = fl;
    for (int unsigned i = 0; i < 4; i++)
      acc[i] = iv && !fl && (sbq[i].size() != i + 2);
    @(negedge clk);
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fl)          sbq[i].delete();
      else if (acc[i]) sbq[i].push_back({ins, pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; IF_flush = 1'b0;
    InsIn = '0; PC_In = '0;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("reset count", 64'(cntA[i]), 64'd0);
      chk("reset in_ready", 64'(irA[i]), 64'd1);
      chk("reset PC_out", 64'(pcA[i]), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill DEPTH=2 while decode stalls, then pop in order
    step(1'b1, 32'hAAAA0001, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB0002, 32'h4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("fill count", 64'(cntA[0]), 64'd2);
      chk("fill in_ready", 64'(irA[0]), 64'd0);
      chk("fill InsOut", 64'(insA[0]), 64'hAAAA0001);
      chk("fill PC_out", 64'(pcA[0]), 64'h0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop1 InsOut", 64'(insA[0]), 64'hBBBB0002);
    chk("pop1 PC_out", 64'(pcA[0]), 64'h4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop2 out_valid", 64'(ovA[0]), 64'd0);
    chk("pop2 InsOut", 64'(insA[0]), 64'h0);

    // Concurrent push/pop at count=1
    step(1'b1, 32'h11110000, 32'h100, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 32'h11110000 + 32'(k), 32'h100 + 32'(4 * k), 1'b1, 1'b0);
      chk("concurrent count", 64'(cntA[0]), 64'd1);
      chk("concurrent PC_out", 64'(pcA[0]), 64'h100 + 64'(4 * k));
    end
    drain(1);

    // Flush at count=3 with in_valid held
    for (int k = 0; k < 3; k++) step(1'b1, 32'hC0DE0000 + 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
    chk("preflush count D4", 64'(cntA[2]), 64'd3);
    step(1'b1, 32'hDEADBEEF, 32'h300, 1'b0, 1'b1);
    in_valid = 1'b0; IF_flush = 1'b0;
    #1;
    chk("flush count D4", 64'(cntA[2]), 64'd0);
    chk("flush out_valid D4", 64'(ovA[2]), 64'd0);
    chk("flush InsOut D4", 64'(insA[2]), 64'h0);
    chk("flush in_ready D4", 64'(irA[2]), 64'd1);

    // Full edge on DEPTH=3: pop while full with input waiting
    for (int k = 0; k < 3; k++) step(1'b1, 32'hF0000000 + 32'(k), 32'h400 + 32'(4 * k), 1'b0, 1'b0);
    chk("full in_ready D3", 64'(irA[1]), 64'd0);
    step(1'b1, 32'hF00000FF, 32'h4F0, 1'b1, 1'b0);
    chk("fullpop count D3", 64'(cntA[1]), 64'd2);
    chk("fullpop in_ready D3", 64'(irA[1]), 64'd1);
    chk("fullpop head D3", 64'(pcA[1]), 64'h404);
    step(1'b1, 32'hF00000FF, 32'h4F0, 1'b0, 1'b0);
    chk("refill count D3", 64'(cntA[1]), 64'd3);
    drain(6);

    // Asynchronous reset between edges at count=2
    step(1'b1, 32'h55550000, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h55550001, 32'h504, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("async count", 64'(cntA[i]), 64'd0);
      chk("async out_valid", 64'(ovA[i]), 64'd0);
      chk("async head", {insA[i], pcA[i]}, 64'd0);
      chk("async in_ready", 64'(irA[i]), 64'd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 32'h77770000, 32'h600, 1'b0, 1'b0);
    chk("postreset InsOut", 64'(insA[0]), 64'h77770000);
    chk("postreset PC_out", 64'(pcA[0]), 64'h600);
    drain(1);

    // Random soak; DEPTH=5 plus the others checked against their queues
    for (int k = 0; k < 1000; k++)
      step(1'($urandom_range(0, 9) < 6), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
